// File: rtl/tff_arb_pkg.sv
// Shared constants, controller state encoding and index-width helper for tff_bank_arbiter.
package tff_arb_pkg;

    localparam int unsigned TFF_NREQ   = 4;
    localparam int unsigned TFF_WIDTH  = 8;
    localparam int unsigned TFF_MASK_W = TFF_WIDTH;
    localparam int unsigned TFF_CNT_W  = 16;

    // Priority-ordered controller state, derived from inputs each cycle
    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_GRANT = 2'd1,
        CTRL_LOAD  = 2'd2,
        CTRL_RESET = 2'd3
    } ctrl_e;

    // ceil(log2(n)), with a floor of 1 so a 1-bit index is always available
    function automatic int unsigned tff_idw(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: searches upward from ptr, wrapping at NREQ-1.
module rr_arbiter
    import tff_arb_pkg::*;
#(
    parameter int unsigned NREQ = TFF_NREQ,
    parameter int unsigned IDW  = tff_idw(TFF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en_arb,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  win_id,
    output logic            valid
);

    logic [IDW-1:0] idx;

    // First requester at or after ptr wins; later hits are ignored so gnt stays one-hot
    always_comb begin
        gnt    = '0;
        win_id = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = IDW'((int'(ptr) + k) % int'(NREQ));
            if (en_arb && !valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                win_id   = idx;
            end
        end
    end

endmodule

// File: rtl/tff_bank_arbiter.sv
// Round-robin shared T flip-flop bank with configuration load path.
// Optional saturating grant counter enabled by TFF_ARB_GRANT_CNT_EN.
module tff_bank_arbiter
    import tff_arb_pkg::*;
#(
    parameter int unsigned NREQ  = TFF_NREQ,
    parameter int unsigned WIDTH = TFF_MASK_W,
    parameter int unsigned IDW   = tff_idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] mask,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [IDW-1:0]        last_id,
    output logic                  busy
`ifdef TFF_ARB_GRANT_CNT_EN
    ,
    output logic [TFF_CNT_W-1:0]  gnt_cnt
`endif
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic [WIDTH-1:0] mask_arr [NREQ];
    logic [IDW-1:0]   win_id;
    logic             win_vld;
    logic             en_arb;
    ctrl_e            ctrl_c;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            mask_arr[i] = mask[i*int'(WIDTH) +: WIDTH];
        end
    end

    // Reset also blocks grants so an in-flight request is dropped rather than deferred
    assign en_arb = en & ~load & ~rst;
    assign busy   = en & ~load & (|req);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req    (req),
        .ptr    (ptr_q),
        .en_arb (en_arb),
        .gnt    (gnt),
        .win_id (win_id),
        .valid  (win_vld)
    );

    always_comb begin
        ctrl_c = CTRL_IDLE;
        if (rst) begin
            ctrl_c = CTRL_RESET;
        end else if (load) begin
            ctrl_c = CTRL_LOAD;
        end else if (en && (|req)) begin
            ctrl_c = CTRL_GRANT;
        end
    end

    always_comb begin
        q_d       = q_q;
        ptr_d     = ptr_q;
        last_id_d = last_id_q;
        case (ctrl_c)
            CTRL_LOAD: q_d = load_val;
            CTRL_GRANT: begin
                if (win_vld) begin
                    q_d       = q_q ^ mask_arr[win_id];
                    last_id_d = win_id;
                    ptr_d     = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= '0;
            ptr_q     <= '0;
            last_id_q <= '0;
        end else begin
            q_q       <= q_d;
            ptr_q     <= ptr_d;
            last_id_q <= last_id_d;
        end
    end

    assign q       = q_q;
    assign last_id = last_id_q;

`ifdef TFF_ARB_GRANT_CNT_EN
    logic [TFF_CNT_W-1:0] cnt_q;

    // Saturates at all-ones; a load clears it
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt_q <= '0;
        end else if (win_vld && (cnt_q != {TFF_CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + TFF_CNT_W'(1);
        end
    end

    assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tff_bank_arbiter.sv
// Table-driven directed bench for tff_bank_arbiter plus hand-written reset/pointer sequences.
module tb_tff_bank_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] mask;
    logic        load;
    logic [7:0]  load_val;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [1:0]  last_id;
    logic        busy;
`ifdef TFF_ARB_GRANT_CNT_EN
    logic [15:0] gnt_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        load;
        logic [3:0]  req;
        logic [31:0] mask;
        logic [7:0]  lv;
        logic [3:0]  exp_gnt;
        logic        exp_busy;
        logic [7:0]  exp_q;
        logic [1:0]  exp_lid;
    } vec_t;

    localparam logic [31:0] M_CYC = 32'h0804_0201;
    localparam logic [31:0] M_0F  = 32'h0000_000F;
    localparam logic [31:0] M_Z   = 32'h0000_0000;

    vec_t vecs [20];
    vec_t hand [5];

    tff_bank_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .mask     (mask),
        .load     (load),
        .load_val (load_val),
        .gnt      (gnt),
        .q        (q),
        .last_id  (last_id),
        .busy     (busy)
`ifdef TFF_ARB_GRANT_CNT_EN
        ,
        .gnt_cnt  (gnt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive on the falling edge, check combinational outputs, then registered ones after the edge
    task automatic step(input string nm, input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        en       = v.en;
        load     = v.load;
        req      = v.req;
        mask     = v.mask;
        load_val = v.lv;
        #1;
        check({nm, " gnt"},  32'(gnt),  32'(v.exp_gnt));
        check({nm, " busy"}, 32'(busy), 32'(v.exp_busy));
        @(posedge clk);
        #1;
        check({nm, " q"},       32'(q),       32'(v.exp_q));
        check({nm, " last_id"}, 32'(last_id), 32'(v.exp_lid));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; req = '0; mask = '0; load_val = '0;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'hF, M_CYC, 8'h00, 4'h0, 1'b1, 8'h00, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'hF, M_CYC, 8'h00, 4'h0, 1'b1, 8'h00, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h1, M_0F,  8'h00, 4'h1, 1'b1, 8'h0F, 2'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'h1, M_0F,  8'h00, 4'h1, 1'b1, 8'h00, 2'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'hF, M_CYC, 8'h00, 4'h0, 1'b1, 8'h00, 2'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'hF, M_CYC, 8'h00, 4'h1, 1'b1, 8'h01, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'hF, M_CYC, 8'h00, 4'h2, 1'b1, 8'h03, 2'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'hF, M_CYC, 8'h00, 4'h4, 1'b1, 8'h07, 2'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'hF, M_CYC, 8'h00, 4'h8, 1'b1, 8'h0F, 2'd3};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'h2, M_CYC, 8'hA5, 4'h0, 1'b0, 8'hA5, 2'd3};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'h2, M_CYC, 8'h00, 4'h2, 1'b1, 8'hA7, 2'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'h4, M_CYC, 8'h00, 4'h0, 1'b0, 8'hA7, 2'd1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'h4, M_CYC, 8'h00, 4'h0, 1'b0, 8'hA7, 2'd1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'h4, M_CYC, 8'h00, 4'h0, 1'b0, 8'hA7, 2'd1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 4'h4, M_CYC, 8'h00, 4'h4, 1'b1, 8'hA3, 2'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 4'h1, M_Z,   8'h00, 4'h1, 1'b1, 8'hA3, 2'd0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 4'h9, M_CYC, 8'h00, 4'h8, 1'b1, 8'hAB, 2'd3};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 4'h0, M_CYC, 8'h00, 4'h0, 1'b0, 8'hAB, 2'd3};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 4'hF, M_CYC, 8'h3C, 4'h0, 1'b0, 8'h3C, 2'd3};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 4'hF, M_CYC, 8'hFF, 4'h0, 1'b0, 8'h00, 2'd0};

        // Reset mid-stream (mask changed so a missed reset would leave q nonzero),
        // then a reset after a grant to 1 must bring the pointer back to 0
        hand[0] = '{1'b0, 1'b1, 1'b0, 4'h8, M_CYC,         8'h00, 4'h8, 1'b1, 8'h08, 2'd3};
        hand[1] = '{1'b1, 1'b1, 1'b0, 4'h8, 32'h8004_0201, 8'h00, 4'h0, 1'b1, 8'h00, 2'd0};
        hand[2] = '{1'b0, 1'b1, 1'b0, 4'h2, M_CYC,         8'h00, 4'h2, 1'b1, 8'h02, 2'd1};
        hand[3] = '{1'b1, 1'b1, 1'b0, 4'hF, M_CYC,         8'h00, 4'h0, 1'b1, 8'h00, 2'd0};
        hand[4] = '{1'b0, 1'b1, 1'b0, 4'hF, M_CYC,         8'h00, 4'h1, 1'b1, 8'h01, 2'd0};

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end
        for (int i = 0; i < 5; i++) begin
            step($sformatf("seq%0d", i), hand[i]);
        end

`ifdef TFF_ARB_GRANT_CNT_EN
        step("cnt_rst", '{1'b1, 1'b1, 1'b0, 4'h0, M_CYC, 8'h00, 4'h0, 1'b0, 8'h00, 2'd0});
        check("cnt after reset", 32'(gnt_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0; en = 1'b1; load = 1'b0; req = 4'h1; mask = M_Z;
        repeat (3) @(posedge clk);
        #1;
        check("cnt after 3 grants", 32'(gnt_cnt), 32'h3);
        repeat (70000) @(posedge clk);
        #1;
        check("cnt saturated", 32'(gnt_cnt), 32'hFFFF);
        @(negedge clk);
        load = 1'b1; load_val = 8'h5A;
        @(posedge clk);
        #1;
        check("cnt cleared by load", 32'(gnt_cnt), 32'h0);
        check("q after load", 32'(q), 32'h5A);
        @(negedge clk);
        load = 1'b0; req = 4'h0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
